word_serializer: RTL and testbench

Upstream feeder for the serial divisible-by-three checker. Accepts parallel WIDTH-bit words over a valid/ready handshake and emits them one bit per cycle, MSB first, with word-boundary markers so the checker can restart per word. A one-word holding register lets the next word be accepted while the current one shifts out, so consecutive words stream with no idle bit slots.

---
 rtl/word_serializer_pkg.sv | 25 ++
 rtl/word_serializer.sv | 90 +++++++++
 tb/tb_word_serializer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the serial divisible-by-three datapath:
// serializer FSM encoding, default word width and counter sizing.
package word_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int unsigned SER_DEFAULT_WIDTH = 8;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int unsigned ser_clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial word feeder, MSB first, with first/last bit markers and a
// one-word holding register so consecutive words stream without gaps.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             ser_last
);

  localparam int unsigned    CW      = ser_clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  ser_state_e       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] pend_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;

  logic accept;
  logic consume;
  logic word_done;

  // The holding register is full exactly when in_ready_q is low.
  assign accept    = in_valid & in_ready_q;
  assign consume   = (state_q == SER_SHIFT) & ser_ready;
  assign word_done = consume & (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SER_IDLE;
      shift_q    <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        SER_IDLE: begin
          if (accept) begin
            shift_q <= in_data;
            cnt_q   <= CNT_TOP;
            state_q <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (word_done) begin
            if (!in_ready_q) begin
              shift_q    <= pend_q;
              cnt_q      <= CNT_TOP;
              in_ready_q <= 1'b1;
            end else if (accept) begin
              shift_q <= in_data;
              cnt_q   <= CNT_TOP;
            end else begin
              // Final shift flushes the register so ser_bit idles low.
              shift_q <= shift_q << 1;
              state_q <= SER_IDLE;
            end
          end else begin
            if (consume) begin
              shift_q <= shift_q << 1;
              cnt_q   <= cnt_q - 1'b1;
            end
            if (accept) begin
              pend_q     <= in_data;
              in_ready_q <= 1'b0;
            end
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_valid = (state_q == SER_SHIFT);
  assign ser_bit   = shift_q[WIDTH-1];
  assign ser_first = ser_valid & (cnt_q == CNT_TOP);
  assign ser_last  = ser_valid & (cnt_q == '0);

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: queue-based word model for WIDTH=8
// plus a directed stream on a WIDTH=2 instance.
module tb_word_serializer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ser_ready;
  logic       ser_valid;
  logic       ser_bit;
  logic       ser_first;
  logic       ser_last;

  logic       in_valid2;
  logic [1:0] in_data2;
  logic       in_ready2;
  logic       ser_ready2;
  logic       ser_valid2;
  logic       ser_bit2;
  logic       ser_first2;
  logic       ser_last2;

  int unsigned n_checks;
  int unsigned n_errors;

  word_serializer #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_ready (ser_ready),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_first (ser_first),
    .ser_last  (ser_last)
  );

  word_serializer #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid2),
    .in_data   (in_data2),
    .in_ready  (in_ready2),
    .ser_ready (ser_ready2),
    .ser_valid (ser_valid2),
    .ser_bit   (ser_bit2),
    .ser_first (ser_first2),
    .ser_last  (ser_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Model: words in flight (front is being emitted), bits already emitted of front.
  int unsigned mq[$];
  int unsigned mpos;
  bit          m_known;

  function automatic logic m_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic m_ready();
    return mq.size() < 2;
  endfunction

  function automatic logic m_bit();
    int unsigned w;
    w = mq[0];
    return ((w >> (7 - mpos)) & 1) != 0;
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic rst);
    logic acc;
    logic cons;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    ser_ready = r;
    reset     = rst;
    if (m_known) begin
      check("in_ready", in_ready, m_ready());
      check("ser_valid", ser_valid, m_valid());
      check("ser_first", ser_first, m_valid() && mpos == 0);
      check("ser_last", ser_last, m_valid() && mpos == 7);
      if (m_valid()) check("ser_bit", ser_bit, m_bit());
    end
    acc  = v && m_ready() && !rst;
    cons = m_valid() && r && !rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mpos    = 0;
      m_known = 1'b1;
    end else begin
      if (cons) begin
        mpos++;
        if (mpos == 8) begin
          void'(mq.pop_front());
          mpos = 0;
        end
      end
      if (acc) mq.push_back(int'(d));
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] exp2 [5];
    logic       rdy2 [5];
    n_checks   = 0;
    n_errors   = 0;
    m_known    = 1'b0;
    mpos       = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    ser_ready  = 1'b1;
    in_valid2  = 1'b0;
    in_data2   = '0;
    ser_ready2 = 1'b1;

    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    #1;
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_ser_bit", ser_bit, 1'b0);
    check("rst_ser_first", ser_first, 1'b0);
    check("rst_ser_last", ser_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_w2_valid", ser_valid2, 1'b0);
    check("rst_w2_ready", in_ready2, 1'b1);

    // Single word, then two words back to back with in_valid held.
    step(1'b1, 8'h0F, 1'b1, 1'b0);
    idle(10);
    step(1'b1, 8'h03, 1'b1, 1'b0);
    step(1'b1, 8'h05, 1'b1, 1'b0);
    idle(17);

    // Direct load on the last-bit cycle with the holding register empty.
    step(1'b1, 8'h03, 1'b1, 1'b0);
    idle(7);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    idle(10);

    // Stall for three cycles after the second bit.
    step(1'b1, 8'h81, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(10);

    // Reset mid-word with the holding register full, then a clean word.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 8'h22, 1'b1, 1'b1);
    #1;
    check("mid_rst_valid", ser_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    step(1'b1, 8'h06, 1'b1, 1'b0);
    idle(10);

    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 199) == 0);
    end
    idle(20);

    // WIDTH=2: 2'b11 then 2'b10 streamed with in_valid held for two edges.
    exp2[0] = 4'b1110; exp2[1] = 4'b1101; exp2[2] = 4'b1110;
    exp2[3] = 4'b1001; exp2[4] = 4'b0000;
    rdy2[0] = 1'b1; rdy2[1] = 1'b0; rdy2[2] = 1'b1; rdy2[3] = 1'b1; rdy2[4] = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b1;
    in_data2  = 2'b11;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid2 = (c == 0);
      in_data2  = 2'b10;
      check("w2_valid", ser_valid2, exp2[c][3]);
      if (exp2[c][3]) check("w2_bit", ser_bit2, exp2[c][2]);
      check("w2_first", ser_first2, exp2[c][1]);
      check("w2_last", ser_last2, exp2[c][0]);
      check("w2_ready", in_ready2, rdy2[c]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
